serial_deframer: RTL and testbench

//  Consumes the 1-bit stream leaving the final data_path stage and rebuilds parallel words.

---
 rtl/serial_deframer_pkg.sv | 14 +
 rtl/deframer_fifo.sv | 50 +++++
 rtl/serial_deframer.sv | 132 +++++++++++++
 tb/tb_serial_deframer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_deframer_pkg.sv
// serial_deframer_pkg: shared state type and helpers for the serial deframer
package serial_deframer_pkg;

   typedef enum logic {HUNT, LOCKED} state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic even_par(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/deframer_fifo.sv
// deframer_fifo: show-ahead FIFO with wrap-bit pointers, simultaneous push/pop allowed when full
module deframer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic             do_push, do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

   // pointer advance
   always_comb begin
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
   end

   // pointer registers, flushed by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // storage; contents are never observed while empty so no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/serial_deframer.sv
// serial_deframer: sync hunt, MSB-first word packing and output FIFO; optional parity via DEFRAMER_PARITY_EN
module serial_deframer
   import serial_deframer_pkg::*;
#(
   parameter int                  DATA_W       = 8,
   parameter int                  SYNC_LEN     = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'hA5,
   parameter int                  FRAME_WORDS  = 4,
   parameter int                  FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in,
   input  logic              in_en,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              locked,
   output logic              overflow,
   output logic              par_err
);

`ifdef DEFRAMER_PARITY_EN
   localparam int BIT_MAX = DATA_W;
   localparam int WSR_W   = DATA_W;
`else
   localparam int BIT_MAX = DATA_W - 1;
   localparam int WSR_W   = DATA_W - 1;
`endif
   localparam int BW = cnt_w(BIT_MAX + 1);
   localparam int WW = cnt_w(FRAME_WORDS);

   state_e              state_q, state_d;
   logic [SYNC_LEN-2:0] sync_q, sync_d;
   logic [WSR_W-1:0]    word_q, word_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [WW-1:0]       wcnt_q, wcnt_d;
   logic                push_q, push_d;
   logic [DATA_W-1:0]   pdata_q, pdata_d;
   logic                perr_q, perr_d;
   logic                ovf_q, ovf_d;
   logic                full, empty;

   assign locked    = (state_q == LOCKED);
   assign out_valid = !empty;
   assign overflow  = ovf_q;
   assign par_err   = perr_q;

   // hunt/lock FSM and capture path; a completed word is registered so it lands in the FIFO one edge later
   always_comb begin
      state_d = state_q;
      sync_d  = sync_q;
      word_d  = word_q;
      bit_d   = bit_q;
      wcnt_d  = wcnt_q;
      push_d  = 1'b0;
      pdata_d = pdata_q;
      perr_d  = 1'b0;
      ovf_d   = ovf_q | (push_q & full & ~out_ready);
      if (in_en) begin
         if (state_q == HUNT) begin
            sync_d = (SYNC_LEN-1)'({sync_q, in});
            if ({sync_q, in} == SYNC_PATTERN) begin
               state_d = LOCKED;
               bit_d   = '0;
               wcnt_d  = '0;
            end
         end else begin
            bit_d  = bit_q + 1'b1;
            word_d = WSR_W'({word_q, in});
            if (bit_q == BW'(BIT_MAX)) begin
               bit_d  = '0;
               wcnt_d = wcnt_q + 1'b1;
`ifdef DEFRAMER_PARITY_EN
               word_d  = word_q;
               pdata_d = word_q;
               perr_d  = even_par(64'(word_q)) ^ in;
               push_d  = ~perr_d;
`else
               pdata_d = {word_q, in};
               push_d  = 1'b1;
`endif
               if (wcnt_q == WW'(FRAME_WORDS - 1)) begin
                  state_d = HUNT;
                  sync_d  = '0;
                  wcnt_d  = '0;
               end
            end
         end
      end
   end

   // capture-path state, cleared asynchronously so a partial word is discarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HUNT;
         sync_q  <= '0;
         word_q  <= '0;
         bit_q   <= '0;
         wcnt_q  <= '0;
         push_q  <= 1'b0;
         pdata_q <= '0;
         perr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         word_q  <= word_d;
         bit_q   <= bit_d;
         wcnt_q  <= wcnt_d;
         push_q  <= push_d;
         pdata_q <= pdata_d;
         perr_q  <= perr_d;
         ovf_q   <= ovf_d;
      end
   end

   deframer_fifo #(
      .WIDTH(DATA_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push_q),
      .din  (pdata_q),
      .full (full),
      .pop  (out_ready),
      .dout (out_data),
      .empty(empty)
   );

endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed checks of sync hunt, word packing, FIFO flow control, reset and parity
module tb_serial_deframer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in = 1'b0;
   logic       in_en = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid, locked, overflow, par_err;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   serial_deframer dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .in_en    (in_en),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .locked   (locked),
      .overflow (overflow),
      .par_err  (par_err)
   );

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      in    = b;
      in_en = 1'b1;
      tick();
      in_en = 1'b0;
   endtask

   task automatic send_raw(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_byte(input logic [7:0] v);
      send_raw(v);
`ifdef DEFRAMER_PARITY_EN
      send_bit(^v);
`endif
   endtask

   task automatic send_chk(input logic [7:0] v, input string tag);
      send_byte(v);
      chk_b({tag, "_early"}, out_valid, 1'b0);
      tick();
      chk_b({tag, "_valid"}, out_valid, 1'b1);
      chk_w({tag, "_data"}, out_data, v);
   endtask

   task automatic send_slow(input logic [7:0] v, input string tag);
      for (int i = 7; i >= 0; i--) begin
         in    = ~v[i];
         in_en = 1'b0;
         tick();
         chk_b({tag, "_idle_valid"}, out_valid, 1'b0);
         chk_b({tag, "_idle_locked"}, locked, 1'b0);
         send_bit(v[i]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      tick();
      chk_b("rst_valid", out_valid, 1'b0);
      chk_w("rst_data", out_data, 8'h00);
      chk_b("rst_locked", locked, 1'b0);
      chk_b("rst_overflow", overflow, 1'b0);
      chk_b("rst_par_err", par_err, 1'b0);
      rst = 1'b1;
      tick();
      out_ready = 1'b1;
      send_raw(8'hA5);
      chk_b("t1_locked", locked, 1'b1);
      send_chk(8'h3C, "t1_w0");
      send_chk(8'hC3, "t1_w1");
      send_byte(8'h11);
      send_byte(8'h22);
      chk_b("t1_frame_end", locked, 1'b0);
      tick();
      tick();
      send_slow(8'hA4, "t2_a4");
      chk_b("t2_after_a4", locked, 1'b0);
      send_slow(8'hA5, "t2_a5");
      chk_b("t2_locked", locked, 1'b1);
      send_chk(8'h5A, "t2_w0");
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h01);
      chk_b("t2_frame_end", locked, 1'b0);
      do_reset();
      out_ready = 1'b0;
      send_raw(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      tick();
      chk_b("t3_full_valid", out_valid, 1'b1);
      chk_b("t3_no_ovf_yet", overflow, 1'b0);
      send_raw(8'hA5);
      send_byte(8'h55);
      tick();
      chk_b("t3_overflow", overflow, 1'b1);
      chk_w("t3_hold", out_data, 8'h11);
      out_ready = 1'b1;
      tick();
      chk_w("t3_pop2", out_data, 8'h22);
      tick();
      chk_w("t3_pop3", out_data, 8'h33);
      tick();
      chk_w("t3_pop4", out_data, 8'h44);
      tick();
      chk_b("t3_empty", out_valid, 1'b0);
      do_reset();
      out_ready = 1'b0;
      send_raw(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_raw(8'hA5);
      send_byte(8'h55);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_b("t4_no_overflow", overflow, 1'b0);
      chk_w("t4_head", out_data, 8'h22);
      out_ready = 1'b1;
      tick();
      chk_w("t4_pop3", out_data, 8'h33);
      tick();
      chk_w("t4_pop4", out_data, 8'h44);
      tick();
      chk_w("t4_new_word", out_data, 8'h55);
      tick();
      chk_b("t4_empty", out_valid, 1'b0);
      do_reset();
      out_ready = 1'b0;
      send_raw(8'hA5);
      send_byte(8'h77);
      tick();
      chk_b("t5_buffered", out_valid, 1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      #2 rst = 1'b0;
      #1;
      chk_b("t5_rst_locked", locked, 1'b0);
      chk_b("t5_rst_valid", out_valid, 1'b0);
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      send_raw(8'hA5);
      send_chk(8'h96, "t5_w0");
`ifdef DEFRAMER_PARITY_EN
      do_reset();
      out_ready = 1'b1;
      send_raw(8'hA5);
      send_chk(8'h81, "t6_good");
      send_raw(8'h81);
      send_bit(1'b1);
      chk_b("t6_par_err", par_err, 1'b1);
      chk_b("t6_bad_valid", out_valid, 1'b0);
      tick();
      chk_b("t6_par_err_pulse", par_err, 1'b0);
      chk_b("t6_dropped", out_valid, 1'b0);
      send_byte(8'h01);
      chk_b("t6_still_locked", locked, 1'b1);
      send_byte(8'h02);
      chk_b("t6_frame_end", locked, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
